// File: rtl/calc_pkg.sv
// Shared calculator types: source count, select width, arbiter state and output bundle.
package calc_pkg;
  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  typedef struct packed {
    logic [NUM_SRC-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               out_valid;
  } arb_out_t;
endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set req bit searching last+1, last+2, ... wrapping to last.
module rr_pick
  import calc_pkg::*;
(
  input  logic [NUM_SRC-1:0] req,
  input  logic [SEL_W-1:0]   last,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);
  always_comb begin
    logic [SEL_W-1:0] idx;
    idx  = '0;
    pick = last;
    any  = |req;
    // Walk farthest-first so the nearest candidate after last overwrites.
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = last + SEL_W'(k);
      if (req[idx]) pick = idx;
    end
  end
endmodule

// File: rtl/out_mux_arbiter.sv
// Round-robin owner of the 4:1 result mux with optional hold limit and a bubble on every handover.
// OUT_ARB_PRIO0_EN: requester 0 gets fixed priority and preempts other owners.
module out_mux_arbiter
  import calc_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  req,
  output logic [NUM_SRC-1:0]  gnt,
  output logic [SEL_W-1:0]    sel,
  output logic                out_valid
);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  arb_state_t        state, state_nx;
  logic [SEL_W-1:0]  last, last_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  arb_out_t          o_q, o_nx;

  logic [SEL_W-1:0]  rr_idx, pick;
  logic              rr_any, prio_rel, timeout, rel_c;

  rr_pick u_pick (
    .req  (req),
    .last (last),
    .pick (rr_idx),
    .any  (rr_any)
  );

`ifdef OUT_ARB_PRIO0_EN
  assign pick     = req[0] ? '0 : rr_idx;
  assign prio_rel = (o_q.sel != '0) && req[0];
`else
  assign pick     = rr_idx;
  assign prio_rel = 1'b0;
`endif

  assign timeout = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
  assign rel_c   = !req[o_q.sel] || timeout || prio_rel;

  always_comb begin
    state_nx = state;
    last_nx  = last;
    hold_nx  = hold_cnt;
    o_nx     = o_q;
    case (state)
      IDLE: begin
        if (rr_any) begin
          o_nx.gnt       = NUM_SRC'(1) << pick;
          o_nx.sel       = pick;
          o_nx.out_valid = 1'b1;
          hold_nx        = HOLD_W'(1);
          state_nx       = GRANT;
        end
      end
      GRANT: begin
        if (rel_c) begin
          // Pointer moves past the owner even on timeout; sel is kept for the mux.
          o_nx.gnt       = '0;
          o_nx.out_valid = 1'b0;
          last_nx        = o_q.sel;
          state_nx       = IDLE;
        end else if (hold_cnt != '1) begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last     <= SEL_W'(NUM_SRC - 1);
      hold_cnt <= '0;
      o_q      <= '0;
    end else begin
      state    <= state_nx;
      last     <= last_nx;
      hold_cnt <= hold_nx;
      o_q      <= o_nx;
    end
  end

  assign gnt       = o_q.gnt;
  assign sel       = o_q.sel;
  assign out_valid = o_q.out_valid;
endmodule
